// File: rtl/jt900h_div.sv
// Iterative restoring divider for TLCS-900H DIV/DIVS: 16/8 and 32/16, signed or unsigned.
// One quotient bit per enabled clock; returns packed {rem, quo}, width-coded write enable and V.
module jt900h_div (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [2:0]  w,
    input  logic        sgn,
    input  logic [31:0] op0,
    input  logic [15:0] op1,
    output logic        busy,
    output logic        done,
    output logic [2:0]  alu_we,
    output logic        v,
    output logic [31:0] dout
);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StFix} state_t;

    state_t      state_q, state_d;
    logic [31:0] op0_q, op0_d;
    logic [15:0] op1_q, op1_d;
    logic        w8_q, w8_d;
    logic        sgn_q, sgn_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  we_q, we_d;
    logic        v_q, v_d;
    logic [31:0] dout_q, dout_d;

    logic        a_sign, b_sign, load_ovf;
    logic [31:0] a_mag;
    logic [15:0] b_mag, a_hi, a_lo;
    logic        msb, ge, sovf;
    logic [16:0] top;
    logic [15:0] sub, rem_n, lo_n, q_fix, r_fix, q_half;
    logic [31:0] packed_res;

    // Operand magnitudes and sign bookkeeping, used in LOAD
    always_comb begin
        if (w8_q) begin
            a_sign = sgn_q & op0_q[15];
            b_sign = sgn_q & op1_q[7];
            a_mag  = {16'h0, a_sign ? 16'(~op0_q[15:0] + 16'd1) : op0_q[15:0]};
            b_mag  = {8'h0, b_sign ? 8'(~op1_q[7:0] + 8'd1) : op1_q[7:0]};
            a_hi   = {8'h0, a_mag[15:8]};
            a_lo   = {8'h0, a_mag[7:0]};
        end else begin
            a_sign = sgn_q & op0_q[31];
            b_sign = sgn_q & op1_q[15];
            a_mag  = a_sign ? 32'(~op0_q + 32'd1) : op0_q;
            b_mag  = b_sign ? 16'(~op1_q + 16'd1) : op1_q;
            a_hi   = a_mag[31:16];
            a_lo   = a_mag[15:0];
        end
        // Also catches a zero divisor
        load_ovf = (a_hi >= b_mag);
    end

    // One restoring step; rem_q < dvs_q holds throughout, so the kept difference fits N bits
    always_comb begin
        msb   = w8_q ? lo_q[7] : lo_q[15];
        top   = {rem_q, msb};
        ge    = (top >= {1'b0, dvs_q});
        sub   = 16'(top - {1'b0, dvs_q});
        rem_n = ge ? sub : top[15:0];
        lo_n  = w8_q ? {8'h0, lo_q[6:0], ge} : {lo_q[14:0], ge};
    end

    // Sign correction and signed range check on the final step's result
    always_comb begin
        q_fix      = qneg_q ? 16'(~lo_n + 16'd1) : lo_n;
        r_fix      = rneg_q ? 16'(~rem_n + 16'd1) : rem_n;
        q_half     = w8_q ? 16'h0080 : 16'h8000;
        sovf       = sgn_q & (qneg_q ? (lo_n > q_half) : (lo_n >= q_half));
        packed_res = w8_q ? {16'h0, r_fix[7:0], q_fix[7:0]} : {r_fix, q_fix};
    end

    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        w8_d    = w8_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 3'b000;
        v_d     = v_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                if (start && (w == 3'b001 || w == 3'b010)) begin
                    op0_d   = op0;
                    op1_d   = op1;
                    w8_d    = w[0];
                    sgn_d   = sgn;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                qneg_d = a_sign ^ b_sign;
                rneg_d = a_sign;
                dvs_d  = b_mag;
                rem_d  = a_hi;
                lo_d   = a_lo;
                cnt_d  = 4'd0;
                if (load_ovf) begin
                    v_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFix;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                rem_d = rem_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == (w8_q ? 4'd7 : 4'd15)) begin
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    state_d = StFix;
                    v_d     = sovf;
                    if (!sovf) begin
                        dout_d = packed_res;
                        we_d   = w8_q ? 3'b010 : 3'b100;
                    end
                end
            end
            StFix: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op0_q   <= 32'h0;
            op1_q   <= 16'h0;
            w8_q    <= 1'b0;
            sgn_q   <= 1'b0;
            rem_q   <= 16'h0;
            lo_q    <= 16'h0;
            dvs_q   <= 16'h0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 3'b000;
            v_q     <= 1'b0;
            dout_q  <= 32'h0;
        end else if (cen) begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            w8_q    <= w8_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            v_q     <= v_d;
            dout_q  <= dout_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign alu_we = we_q;
    assign v      = v_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_jt900h_div.sv
// Bench for jt900h_div: directed and random divisions checked against an integer-arithmetic model.
module tb_jt900h_div;

    logic        rst, clk, cen, start, sgn;
    logic [2:0]  w;
    logic [31:0] op0;
    logic [15:0] op1;
    logic        busy, done, v;
    logic [2:0]  alu_we;
    logic [31:0] dout;

    int          ntests = 0;
    int          nfail = 0;
    bit          cen_rand = 0;
    logic [31:0] exp_dout = 32'h0;

    jt900h_div dut (
        .rst    (rst),
        .clk    (clk),
        .cen    (cen),
        .start  (start),
        .w      (w),
        .sgn    (sgn),
        .op0    (op0),
        .op1    (op1),
        .busy   (busy),
        .done   (done),
        .alu_we (alu_we),
        .v      (v),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; en reports whether the posedge just passed had cen high
    task automatic step(output bit en);
        en = cen;
        @(negedge clk);
        cen = cen_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    function automatic void model(input bit w8, input bit s, input logic [31:0] a_in,
                                  input logic [15:0] b_in, output bit ov, output bit early,
                                  output logic [31:0] res);
        longint      a, b, q, r, n, lim, aa, ab;
        logic [15:0] a16, qq, rr;
        logic [7:0]  b8;
        n = w8 ? 8 : 16;
        if (w8) begin
            a16 = a_in[15:0];
            b8  = b_in[7:0];
            a   = s ? longint'($signed(a16)) : longint'(a16);
            b   = s ? longint'($signed(b8)) : longint'(b8);
        end else begin
            a = s ? longint'($signed(a_in)) : longint'(a_in);
            b = s ? longint'($signed(b_in)) : longint'(b_in);
        end
        res   = 32'h0;
        aa    = (a < 0) ? -a : a;
        ab    = (b < 0) ? -b : b;
        early = (b == 0) || ((aa >> n) >= ab);
        ov    = early;
        if (b == 0) return;
        q   = a / b;
        r   = a % b;
        lim = longint'(1) << (n - 1);
        if (s) ov = ov || (q > lim - 1) || (q < -lim);
        qq  = q[15:0];
        rr  = r[15:0];
        res = w8 ? {16'h0, rr[7:0], qq[7:0]} : {rr, qq};
    endfunction

    task automatic run(input logic [2:0] wi, input bit s, input logic [31:0] a,
                       input logic [15:0] b, input bit poke, input string tag);
        bit          ov, early, en, got, sampled, busy_ok;
        logic [31:0] res;
        int          lat, exp_lat;
        model(wi[0], s, a, b, ov, early, res);
        exp_lat = early ? 2 : (wi[0] ? 10 : 18);
        got = 0; sampled = 0; busy_ok = 1; lat = 0;
        w = wi; sgn = s; op0 = a; op1 = b; start = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            step(en);
            if (en) begin
                lat++;
                if (!sampled) begin
                    sampled = 1;
                    start = 1'b0;
                    w = 3'($urandom); sgn = 1'($urandom);
                    op0 = $urandom; op1 = 16'($urandom);
                end else if (poke && lat == 4) begin
                    start = 1'b1;
                end else if (poke && lat == 5) begin
                    start = 1'b0;
                end
                if (done) got = 1;
                else if (!busy) busy_ok = 0;
            end
        end
        start = 1'b0;
        check({tag, ".done"}, 32'(got), 32'd1);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busy"}, 32'(busy_ok && busy), 32'd1);
        check({tag, ".v"}, 32'(v), 32'(ov));
        check({tag, ".dout"}, dout, ov ? exp_dout : res);
        check({tag, ".we"}, 32'(alu_we), ov ? 32'd0 : (wi[0] ? 32'd2 : 32'd4));
        if (!ov) exp_dout = res;
        for (int i = 0; i < 100; i++) begin
            step(en);
            if (en) break;
            check({tag, ".hold"}, 32'(done), 32'd1);
        end
        check({tag, ".fall"}, {busy, done, alu_we}, 32'd0);
        check({tag, ".vkeep"}, 32'(v), 32'(ov));
    endtask

    initial begin
        bit          en, s;
        logic [2:0]  wr;
        logic [31:0] a;
        logic [15:0] b;
        int          lat, first, second, ndone;
        bit          prev;

        rst = 1'b1; cen = 1'b1; start = 1'b0; w = 3'b000; sgn = 1'b0;
        op0 = 32'h0; op1 = 16'h0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.we", 32'(alu_we), 32'd0);
        check("rst.v", 32'(v), 32'd0);
        check("rst.dout", dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(3'b001, 1'b0, 32'h0000_0107, 16'h0010, 1'b0, "u8");
        check("u8.ref", dout, 32'h0000_0710);
        run(3'b010, 1'b0, 32'h0001_2345, 16'h0100, 1'b1, "u16");
        check("u16.ref", dout, 32'h0045_0123);
        run(3'b001, 1'b1, 32'h0000_FFF9, 16'h0002, 1'b0, "s8");
        check("s8.ref", dout, 32'h0000_FFFD);
        run(3'b001, 1'b0, 32'h0000_1234, 16'h0000, 1'b0, "dz");
        run(3'b001, 1'b0, 32'h0000_1000, 16'h0010, 1'b0, "lovf");
        run(3'b001, 1'b1, 32'h0000_0080, 16'h0001, 1'b0, "sovf");
        check("sovf.keep", dout, 32'h0000_FFFD);

        // Unsupported width codes must not start anything
        w = 3'b100; start = 1'b1;
        repeat (3) step(en);
        w = 3'b011;
        repeat (3) step(en);
        start = 1'b0;
        check("badw", {busy, done}, 32'd0);

        cen_rand = 1;
        run(3'b010, 1'b0, 32'h0001_2345, 16'h0100, 1'b0, "cen");
        for (int i = 0; i < 40; i++) begin
            cen_rand = (i % 2) == 1;
            wr = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
            s  = 1'($urandom_range(0, 1));
            a  = $urandom >> $urandom_range(0, 31);
            if (s && $urandom_range(0, 1) == 1) a = -a;
            b  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 15);
            run(wr, s, a, b, 1'($urandom_range(0, 1)), "rnd");
        end
        cen_rand = 0;
        cen = 1'b1;
        @(negedge clk);

        // start held high: one result every 19 enabled cycles
        w = 3'b010; sgn = 1'b0; op0 = 32'h0001_2345; op1 = 16'h0100; start = 1'b1;
        lat = 0; ndone = 0; first = 0; second = 0; prev = 0;
        for (int i = 0; i < 100 && ndone < 2; i++) begin
            step(en);
            lat++;
            if (done && !prev) begin
                ndone++;
                if (ndone == 1) first = lat; else second = lat;
            end
            prev = done;
        end
        start = 1'b0;
        check("hold.count", ndone, 2);
        check("hold.first", first, 18);
        check("hold.period", second - first, 19);
        check("hold.dout", dout, 32'h0045_0123);
        exp_dout = 32'h0045_0123;
        repeat (2) step(en);
        check("hold.idle", 32'(busy), 32'd0);

        // Reset in the middle of an iteration
        w = 3'b010; sgn = 1'b0; op0 = 32'h0001_2345; op1 = 16'h0100; start = 1'b1;
        step(en);
        start = 1'b0;
        repeat (5) step(en);
        rst = 1'b1;
        #1;
        check("mrst.out", {busy, done, alu_we, v}, 32'd0);
        check("mrst.dout", dout, 32'd0);
        exp_dout = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(3'b001, 1'b1, 32'h0000_0064, 16'h00F9, 1'b0, "post");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
